// File: rtl/syscall_dispatch.sv
// Syscall service dispatcher: decodes R1 on Syscall and runs LED, cycle-snapshot, pause or handshake services.
// Optional REQ watchdog is enabled by defining SYSCALL_TIMEOUT_EN.
module syscall_dispatch #(
  parameter int DATA_W      = 32,
  parameter int LED_W       = 32,
  parameter int CYC_W       = 32,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              Syscall,
  input  logic [DATA_W-1:0] R1,
  input  logic [DATA_W-1:0] R2,
  input  logic              Resume,
  input  logic [4:0]        Svc_Done,
  output logic [4:0]        Svc_Req,
  output logic [DATA_W-1:0] Svc_Arg,
  output logic              Stall,
  output logic [LED_W-1:0]  LedData,
  output logic [CYC_W-1:0]  Cycles,
  output logic              Pause,
  output logic              Bad_Svc,
  output logic              Timeout_Err
);

  typedef enum logic [1:0] {IDLE, REQ, PAUSED, ACK} state_t;

  localparam logic [DATA_W-1:0] SVC_KB_IN       = DATA_W'(16);
  localparam logic [DATA_W-1:0] SVC_SCREEN      = DATA_W'(32);
  localparam logic [DATA_W-1:0] SVC_BITMAP      = DATA_W'(33);
  localparam logic [DATA_W-1:0] SVC_LED         = DATA_W'(34);
  localparam logic [DATA_W-1:0] SVC_COPY_RAM    = DATA_W'(35);
  localparam logic [DATA_W-1:0] SVC_FRAME_FLUSH = DATA_W'(36);
  localparam logic [DATA_W-1:0] SVC_CYCLES      = DATA_W'(49);
  localparam logic [DATA_W-1:0] SVC_PAUSE       = DATA_W'(50);

  state_t             state, state_nx;
  logic [CYC_W-1:0]   cnt;
  logic               resume_q;
  logic [4:0]         req_sel;
  logic               is_led, is_cyc, is_pause;
  logic               stall_c, req_set, req_clr, led_we, cyc_we, bad_set, pause_set, pause_clr;
  logic               done_hit, resume_rise;

  // Full-width decode: any upper bit set makes the code unknown
  always_comb begin
    req_sel = '0;
    case (R1)
      SVC_KB_IN:       req_sel = 5'b00001;
      SVC_SCREEN:      req_sel = 5'b00010;
      SVC_BITMAP:      req_sel = 5'b00100;
      SVC_COPY_RAM:    req_sel = 5'b01000;
      SVC_FRAME_FLUSH: req_sel = 5'b10000;
      default:         req_sel = 5'b00000;
    endcase
  end

  assign is_led      = (R1 == SVC_LED);
  assign is_cyc      = (R1 == SVC_CYCLES);
  assign is_pause    = (R1 == SVC_PAUSE);
  assign done_hit    = |(Svc_Done & Svc_Req);
  assign resume_rise = Resume & ~resume_q;

`ifdef SYSCALL_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr;
  logic             tmo_hit, tmo_set;

  assign tmo_hit = (state == REQ) && (tmr == TMR_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N)              tmr <= '0;
    else if (req_set)        tmr <= '0;
    else if (state == REQ)   tmr <= tmr + TMR_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N)       Timeout_Err <= 1'b0;
    else if (tmo_set) Timeout_Err <= 1'b1;
  end
`else
  logic tmo_unused;
  assign tmo_unused  = (TIMEOUT_CYC != 0);
  assign Timeout_Err = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    stall_c   = 1'b0;
    req_set   = 1'b0;
    req_clr   = 1'b0;
    led_we    = 1'b0;
    cyc_we    = 1'b0;
    bad_set   = 1'b0;
    pause_set = 1'b0;
    pause_clr = 1'b0;
`ifdef SYSCALL_TIMEOUT_EN
    tmo_set   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (Syscall) begin
          if (|req_sel) begin
            stall_c  = 1'b1;
            req_set  = 1'b1;
            state_nx = REQ;
          end else if (is_pause) begin
            stall_c   = 1'b1;
            pause_set = 1'b1;
            state_nx  = PAUSED;
          end else if (is_led) begin
            led_we = 1'b1;
          end else if (is_cyc) begin
            cyc_we = 1'b1;
          end else begin
            bad_set = 1'b1;
          end
        end
      end
      REQ: begin
        stall_c = 1'b1;
        // Done at the watchdog limit still counts as a normal completion
        if (done_hit) begin
          req_clr  = 1'b1;
          state_nx = ACK;
        end
`ifdef SYSCALL_TIMEOUT_EN
        else if (tmo_hit) begin
          req_clr  = 1'b1;
          tmo_set  = 1'b1;
          state_nx = ACK;
        end
`endif
      end
      PAUSED: begin
        stall_c = 1'b1;
        if (resume_rise) begin
          pause_clr = 1'b1;
          state_nx  = ACK;
        end
      end
      ACK: begin
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign Stall = stall_c & RST_N;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      Svc_Req  <= '0;
      Svc_Arg  <= '0;
      LedData  <= '0;
      Cycles   <= '0;
      cnt      <= '0;
      Pause    <= 1'b0;
      Bad_Svc  <= 1'b0;
      resume_q <= 1'b0;
    end else begin
      resume_q <= Resume;
      if (!Pause) cnt <= cnt + CYC_W'(1);
      if (req_set) begin
        Svc_Req <= req_sel;
        Svc_Arg <= R2;
      end else if (req_clr) begin
        Svc_Req <= '0;
      end
      if (led_we)         LedData <= R2[LED_W-1:0];
      if (cyc_we)         Cycles  <= cnt;
      if (pause_set)      Pause   <= 1'b1;
      else if (pause_clr) Pause   <= 1'b0;
      if (bad_set)        Bad_Svc <= 1'b1;
    end
  end

endmodule

// File: tb/tb_syscall_dispatch.sv
// Directed testbench for syscall_dispatch: LED, handshake, pause/resume, cycle snapshot, unknown code, reset abort, watchdog.
module tb_syscall_dispatch;
  localparam int DATA_W      = 32;
  localparam int LED_W       = 32;
  localparam int CYC_W       = 4;
  localparam int TIMEOUT_CYC = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              syscall;
  logic [DATA_W-1:0] r1, r2;
  logic              resume;
  logic [4:0]        svc_done;
  logic [4:0]        svc_req;
  logic [DATA_W-1:0] svc_arg;
  logic              stall;
  logic [LED_W-1:0]  led_data;
  logic [CYC_W-1:0]  cycles;
  logic              pause;
  logic              bad_svc;
  logic              timeout_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  syscall_dispatch #(
    .DATA_W(DATA_W), .LED_W(LED_W), .CYC_W(CYC_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .Syscall(syscall), .R1(r1), .R2(r2), .Resume(resume),
    .Svc_Done(svc_done), .Svc_Req(svc_req), .Svc_Arg(svc_arg), .Stall(stall),
    .LedData(led_data), .Cycles(cycles), .Pause(pause), .Bad_Svc(bad_svc),
    .Timeout_Err(timeout_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; syscall = 1'b0; resume = 1'b0; svc_done = '0; r1 = '0; r2 = '0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; syscall = 1'b1; r1 = 32'd36; r2 = 32'd5; resume = 1'b0; svc_done = '0;
    tick(); tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_stall got=%0h exp=0", stall); end
    total++; if (svc_req !== 5'b0) begin bad++; $display("FAIL rst_req got=%0h exp=0", svc_req); end
    total++; if (svc_arg !== 32'd0) begin bad++; $display("FAIL rst_arg got=%0h exp=0", svc_arg); end
    total++; if (led_data !== 32'd0) begin bad++; $display("FAIL rst_led got=%0h exp=0", led_data); end
    total++; if (cycles !== 4'd0) begin bad++; $display("FAIL rst_cycles got=%0h exp=0", cycles); end
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL rst_pause got=%0h exp=0", pause); end
    total++; if (bad_svc !== 1'b0) begin bad++; $display("FAIL rst_bad got=%0h exp=0", bad_svc); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL rst_tmo got=%0h exp=0", timeout_err); end
    syscall = 1'b0; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_led;
    do_reset();
    syscall = 1'b1; r1 = 32'd34; r2 = 32'h0000_00A5;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL led_stall got=%0h exp=0", stall); end
    tick(); syscall = 1'b0; #1;
    total++; if (led_data !== 32'h0000_00A5) begin bad++; $display("FAIL led_a5 got=%0h exp=a5", led_data); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL led_stall2 got=%0h exp=0", stall); end
    syscall = 1'b1; r2 = 32'hDEAD_BEEF;
    tick(); syscall = 1'b0;
    total++; if (led_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL led_full got=%0h exp=deadbeef", led_data); end
  endtask

  task automatic test_handshake;
    do_reset();
    syscall = 1'b1; r1 = 32'd36; r2 = 32'd7;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL hs_idle_stall got=%0h exp=1", stall); end
    total++; if (svc_req !== 5'b0) begin bad++; $display("FAIL hs_idle_req got=%0h exp=0", svc_req); end
    tick();
    total++; if (svc_req !== 5'b10000) begin bad++; $display("FAIL hs_req got=%0h exp=10", svc_req); end
    total++; if (svc_arg !== 32'd7) begin bad++; $display("FAIL hs_arg got=%0h exp=7", svc_arg); end
    repeat (2) tick();
    svc_done = 5'b01111;
    tick();
    total++; if (svc_req !== 5'b10000) begin bad++; $display("FAIL hs_other_done got=%0h exp=10", svc_req); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL hs_req_stall got=%0h exp=1", stall); end
    svc_done = 5'b10000;
    tick(); svc_done = 5'b0; #1;
    total++; if (svc_req !== 5'b0) begin bad++; $display("FAIL hs_done_clr got=%0h exp=0", svc_req); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hs_ack_stall got=%0h exp=0", stall); end
    tick();
    r1 = 32'd32; r2 = 32'h55; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%0h exp=1", stall); end
    tick();
    total++; if (svc_req !== 5'b00010) begin bad++; $display("FAIL b2b_req got=%0h exp=2", svc_req); end
    total++; if (svc_arg !== 32'h55) begin bad++; $display("FAIL b2b_arg got=%0h exp=55", svc_arg); end
    svc_done = 5'b00010;
    tick(); svc_done = 5'b0; #1;
    total++; if (svc_req !== 5'b0) begin bad++; $display("FAIL b2b_clr got=%0h exp=0", svc_req); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL b2b_ack got=%0h exp=0", stall); end
    syscall = 1'b0;
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hs_idle_end got=%0h exp=0", stall); end
  endtask

  task automatic test_pause;
    do_reset();
    tick(); tick();
    syscall = 1'b1; r1 = 32'd50; resume = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL pz_idle_stall got=%0h exp=1", stall); end
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL pz_idle_pause got=%0h exp=0", pause); end
    tick();
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL pz_enter got=%0h exp=1", pause); end
    tick(); tick();
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL pz_held_high got=%0h exp=1", pause); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL pz_stall got=%0h exp=1", stall); end
    resume = 1'b0;
    tick();
    total++; if (pause !== 1'b1) begin bad++; $display("FAIL pz_low got=%0h exp=1", pause); end
    resume = 1'b1;
    tick();
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL pz_exit got=%0h exp=0", pause); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL pz_ack_stall got=%0h exp=0", stall); end
    tick();
    total++; if (pause !== 1'b0) begin bad++; $display("FAIL pz_ack_ignore got=%0h exp=0", pause); end
    r1 = 32'd49; #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL cyc_stall got=%0h exp=0", stall); end
    tick(); syscall = 1'b0; resume = 1'b0;
    total++; if (cycles !== 4'd4) begin bad++; $display("FAIL pz_cycles got=%0d exp=4", cycles); end
  endtask

  task automatic test_wrap;
    do_reset();
    repeat (15) tick();
    syscall = 1'b1; r1 = 32'd49;
    tick();
    total++; if (cycles !== 4'd15) begin bad++; $display("FAIL wrap_max got=%0d exp=15", cycles); end
    tick(); syscall = 1'b0;
    total++; if (cycles !== 4'd0) begin bad++; $display("FAIL wrap_zero got=%0d exp=0", cycles); end
  endtask

  task automatic test_bad_svc;
    do_reset();
    syscall = 1'b1; r1 = 32'd99;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL bad_stall got=%0h exp=0", stall); end
    tick(); syscall = 1'b0;
    total++; if (bad_svc !== 1'b1) begin bad++; $display("FAIL bad_set got=%0h exp=1", bad_svc); end
    for (int i = 1; i <= 10; i++) begin
      syscall = 1'b1; r1 = 32'd34; r2 = i;
      tick();
    end
    syscall = 1'b0;
    total++; if (bad_svc !== 1'b1) begin bad++; $display("FAIL bad_sticky got=%0h exp=1", bad_svc); end
    total++; if (led_data !== 32'd10) begin bad++; $display("FAIL bad_led got=%0h exp=a", led_data); end
    syscall = 1'b1; r1 = 32'h0001_0022; r2 = 32'd77;
    tick(); syscall = 1'b0;
    total++; if (led_data !== 32'd10) begin bad++; $display("FAIL wide_code got=%0h exp=a", led_data); end
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    total++; if (bad_svc !== 1'b0) begin bad++; $display("FAIL bad_clear got=%0h exp=0", bad_svc); end
  endtask

  task automatic test_req_reset;
    do_reset();
    syscall = 1'b1; r1 = 32'd33; r2 = 32'd9;
    tick();
    total++; if (svc_req !== 5'b00100) begin bad++; $display("FAIL rr_req got=%0h exp=4", svc_req); end
    svc_done = 5'b00001;
    tick(); svc_done = 5'b0;
    total++; if (svc_req !== 5'b00100) begin bad++; $display("FAIL rr_ignore got=%0h exp=4", svc_req); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rr_stall got=%0h exp=1", stall); end
    rst_n = 1'b0;
    tick();
    total++; if (svc_req !== 5'b0) begin bad++; $display("FAIL rr_abort_req got=%0h exp=0", svc_req); end
    total++; if (svc_arg !== 32'd0) begin bad++; $display("FAIL rr_abort_arg got=%0h exp=0", svc_arg); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rr_abort_stall got=%0h exp=0", stall); end
    rst_n = 1'b1; #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL rr_no_ack got=%0h exp=1", stall); end
    tick();
    total++; if (svc_req !== 5'b00100) begin bad++; $display("FAIL rr_restart got=%0h exp=4", svc_req); end
    svc_done = 5'b00100;
    tick(); svc_done = 5'b0; syscall = 1'b0;
    total++; if (svc_req !== 5'b0) begin bad++; $display("FAIL rr_done got=%0h exp=0", svc_req); end
    tick();
  endtask

  task automatic test_timeout;
    do_reset();
    syscall = 1'b1; r1 = 32'd16; r2 = 32'd3;
    tick();
    total++; if (svc_req !== 5'b00001) begin bad++; $display("FAIL to_req got=%0h exp=1", svc_req); end
`ifdef SYSCALL_TIMEOUT_EN
    repeat (7) tick();
    total++; if (svc_req !== 5'b00001) begin bad++; $display("FAIL to_pre_limit got=%0h exp=1", svc_req); end
    svc_done = 5'b00001;
    tick(); svc_done = 5'b0;
    total++; if (svc_req !== 5'b0) begin bad++; $display("FAIL to_prio_req got=%0h exp=0", svc_req); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_prio_err got=%0h exp=0", timeout_err); end
    tick(); tick();
    total++; if (svc_req !== 5'b00001) begin bad++; $display("FAIL to_req2 got=%0h exp=1", svc_req); end
    repeat (7) tick();
    total++; if (svc_req !== 5'b00001) begin bad++; $display("FAIL to_pre_limit2 got=%0h exp=1", svc_req); end
    tick();
    total++; if (svc_req !== 5'b0) begin bad++; $display("FAIL to_fire_req got=%0h exp=0", svc_req); end
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_fire_err got=%0h exp=1", timeout_err); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL to_ack got=%0h exp=0", stall); end
    syscall = 1'b0;
    tick();
    total++; if (timeout_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%0h exp=1", timeout_err); end
`else
    repeat (100) tick();
    total++; if (svc_req !== 5'b00001) begin bad++; $display("FAIL to_wait_req got=%0h exp=1", svc_req); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL to_wait_stall got=%0h exp=1", stall); end
    total++; if (timeout_err !== 1'b0) begin bad++; $display("FAIL to_tied got=%0h exp=0", timeout_err); end
    svc_done = 5'b00001;
    tick(); svc_done = 5'b0; syscall = 1'b0;
    total++; if (svc_req !== 5'b0) begin bad++; $display("FAIL to_done got=%0h exp=0", svc_req); end
    tick();
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst_n = 1'b0; syscall = 1'b0; r1 = '0; r2 = '0; resume = 1'b0; svc_done = '0;
    test_reset();
    test_led();
    test_handshake();
    test_pause();
    test_wrap();
    test_bad_svc();
    test_req_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
